wb_ram_arbiter: RTL
===================

Name: wb_ram_arbiter

Overview:
- Round-robin Wishbone B3 arbiter that shares one slave port (typically the on-chip RAM) between nm masters.
- Holds a grant for the whole bus cycle, so cyc-framed bursts are never split.
- Per-grant watchdog aborts a stalled access with err, so a hung slave cannot lock out other masters.
- Sits between the CPU/debug/DMA master ports and the RAM slave in the top-level interconnect.

Parameters:
- nm, 4, number of masters (2..8)
- dw, 32, data width
- aw, 32, address width
- timeout_cycles, 255, max cycles a strobed access may wait for ack/err/rty; 0 disables the watchdog
- tw, 8, watchdog counter width; must satisfy timeout_cycles < 2**tw

Ports:
- wb_clk_i  in  1  clock
- wb_rst_n_i  in  1  reset, asynchronous assert, active-low
- wbm_adr_i  in  nm*aw  master addresses; master k occupies slice [k*aw +: aw]
- wbm_dat_i  in  nm*dw  master write data
- wbm_sel_i  in  nm*4  byte selects
- wbm_cti_i  in  nm*3  cycle type
- wbm_bte_i  in  nm*2  burst type
- wbm_we_i  in  nm  write enables
- wbm_cyc_i  in  nm  cycle requests
- wbm_stb_i  in  nm  strobes
- wbm_ack_o  out  nm  ack, gated to the granted master only
- wbm_err_o  out  nm  err, gated to granted master; also carries watchdog abort
- wbm_rty_o  out  nm  rty, gated to granted master only
- wbm_dat_o  out  dw  slave read data, broadcast to all masters
- wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_cti_o, wbs_bte_o, wbs_we_o, wbs_cyc_o, wbs_stb_o  out  aw/dw/4/3/2/1/1/1  slave-side muxed request
- wbs_ack_i, wbs_err_i, wbs_rty_i  in  1 each  slave responses
- wbs_dat_i  in  dw  slave read data
- grant_o  out  nm  one-hot current grant, for debug/profiling

Behaviour:
- Reset, asynchronous on wb_rst_n_i low:
  - state=IDLE, grant=0, last=nm-1 (master 0 wins first), watchdog=0.
  - All wbm_*_o response bits, wbs_cyc_o, wbs_stb_o and wbs_we_o are 0.
  - Muxed address/data/sel/cti/bte outputs are 0 when nothing is granted.
- States: IDLE, GRANT, ABORT.
- IDLE:
  - If any wbm_cyc_i is set, pick the first requester after last, searching (last+1) mod nm upward with wrap.
  - Register the one-hot grant and set last=winner; go to GRANT next cycle.
  - Latency from cyc to first slave stb is 1 cycle.
- GRANT:
  - Slave outputs are combinationally muxed from the granted master.
  - Response bits are ANDed with grant; wbm_dat_o = wbs_dat_i.
  - If the granted wbm_cyc_i is low, clear the grant and go to IDLE. This gives one dead cycle between any two grants, including back-to-back re-grant of the same master.
  - Other masters' cyc changes are ignored until release.
- Watchdog:
  - Counts in GRANT while the granted stb=1 and wbs_ack_i|wbs_err_i|wbs_rty_i=0.
  - Clears on any response, and whenever stb=0.
  - When count==timeout_cycles and timeout_cycles!=0: that same cycle, force wbs_cyc_o=wbs_stb_o=0 and pulse err to the granted master for one cycle, then go to ABORT.
- ABORT: slave cyc/stb held 0 and no responses forwarded; go to IDLE when the granted wbm_cyc_i drops.
- Simultaneous slave response and watchdog expiry in the same cycle: the slave response wins and the counter clears.
- Single-master case: the lone requester is re-granted after the one IDLE cycle; no starvation possible.
- Reset mid-cycle: the grant drops immediately, and slave cyc/stb drop asynchronously.

Decomposition:
- Shared package wb_arb_pkg holds:
  - state encoding constants IDLE=2'd0, GRANT=2'd1, ABORT=2'd2
  - CTI constants (classic 3'b000, incr 3'b010, end 3'b111)
- One sub-module, wb_rr_pick: combinational round-robin priority picker (inputs req[nm], last index; output one-hot winner plus index). It is reused later for the DMA channel scheduler.

Test Plan:
- Single master: M0 single read of 0x0000_0010, slave acks after 2 cycles → wbs_stb_o rises 1 cycle after cyc; wbm_ack_o=4'b0001 for 1 cycle; others never ack.
- Contention: M0..M3 raise cyc in the same cycle, each doing one access → grant_o sequence 0001, 0010, 0100, 1000, with one IDLE cycle between grants.
- Burst lock: M1 issues a 4-beat incrementing burst (cti 010,010,010,111) while M2 requests → M2 is not granted until M1 drops cyc; all 4 acks go to M1.
- Watchdog: timeout_cycles=8, slave never responds to M2 → wbm_err_o[2] pulses at the 9th strobed cycle; slave cyc drops that cycle; M3 is granted after M2 drops cyc.
- Fairness: M0 and M1 continuously re-request 20 single accesses each → grants strictly alternate; no master receives more than 1 grant more than the other.
- Async reset: assert wb_rst_n_i low mid-burst between clock edges → wbs_cyc_o and grant_o go to 0 without a clock edge; after release, master 0 wins the first arbitration.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared constants for the Wishbone RAM arbiter and the round-robin picker.
// Also used by the DMA channel scheduler.
package wb_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE  = 2'd0;
  localparam arb_state_t GRANT = 2'd1;
  localparam arb_state_t ABORT = 2'd2;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester after `last`, searching
// upward with wrap. The requester at `last` itself has lowest priority.
module wb_rr_pick #(
  parameter int nm = 4,
  parameter int iw = 2
) (
  input  logic [nm-1:0] req,
  input  logic [iw-1:0] last,
  output logic [nm-1:0] winner,
  output logic [iw-1:0] idx,
  output logic          valid
);

  always_comb begin
    int cand;
    winner = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int off = 1; off <= nm; off++) begin
      cand = int'(last) + off;
      if (cand >= nm) cand = cand - nm;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        winner[cand] = 1'b1;
        idx          = iw'(cand);
      end
    end
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one slave among nm masters, holding
// the grant for a whole cyc frame, with a per-grant watchdog that aborts with err.
module wb_ram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int nm             = 4,
  parameter int dw             = 32,
  parameter int aw             = 32,
  parameter int timeout_cycles = 255,
  parameter int tw             = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic [nm*aw-1:0] wbm_adr_i,
  input  logic [nm*dw-1:0] wbm_dat_i,
  input  logic [nm*4-1:0]  wbm_sel_i,
  input  logic [nm*3-1:0]  wbm_cti_i,
  input  logic [nm*2-1:0]  wbm_bte_i,
  input  logic [nm-1:0]    wbm_we_i,
  input  logic [nm-1:0]    wbm_cyc_i,
  input  logic [nm-1:0]    wbm_stb_i,
  output logic [nm-1:0]    wbm_ack_o,
  output logic [nm-1:0]    wbm_err_o,
  output logic [nm-1:0]    wbm_rty_o,
  output logic [dw-1:0]    wbm_dat_o,
  output logic [aw-1:0]    wbs_adr_o,
  output logic [dw-1:0]    wbs_dat_o,
  output logic [3:0]       wbs_sel_o,
  output logic [2:0]       wbs_cti_o,
  output logic [1:0]       wbs_bte_o,
  output logic             wbs_we_o,
  output logic             wbs_cyc_o,
  output logic             wbs_stb_o,
  input  logic             wbs_ack_i,
  input  logic             wbs_err_i,
  input  logic             wbs_rty_i,
  input  logic [dw-1:0]    wbs_dat_i,
  output logic [nm-1:0]    grant_o
);

  localparam int IW = idx_width(nm);

  arb_state_t    state_q, state_d;
  logic [nm-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [tw-1:0] wd_q, wd_d;

  logic [nm-1:0] pick_onehot;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;

  logic g_cyc, g_stb, g_we, slv_resp, expire, fwd, bus_active;

  wb_rr_pick #(.nm(nm), .iw(IW)) u_pick (
    .req    (wbm_cyc_i),
    .last   (last_q),
    .winner (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign g_cyc    = |(grant_q & wbm_cyc_i);
  assign g_stb    = |(grant_q & wbm_stb_i);
  assign g_we     = |(grant_q & wbm_we_i);
  assign slv_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

  // A slave response arriving on the expiry cycle wins, so expiry requires no response.
  assign expire = (timeout_cycles != 0) && (state_q == GRANT) && g_cyc && g_stb &&
                  !slv_resp && (wd_q == tw'(timeout_cycles));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(nm - 1);
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wd_d    = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          grant_d = pick_onehot;
          last_d  = pick_idx;
        end
      end
      GRANT: begin
        if (!g_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (expire) begin
          state_d = ABORT;
        end else if ((timeout_cycles != 0) && g_stb && !slv_resp) begin
          wd_d = wd_q + 1'b1;
        end
      end
      ABORT: begin
        if (!g_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign fwd        = (state_q == GRANT);
  assign bus_active = fwd && !expire;

  // AND-OR mux: with no grant every muxed field collapses to zero.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    for (int k = 0; k < nm; k++) begin
      if (grant_q[k]) begin
        wbs_adr_o = wbs_adr_o | wbm_adr_i[k*aw +: aw];
        wbs_dat_o = wbs_dat_o | wbm_dat_i[k*dw +: dw];
        wbs_sel_o = wbs_sel_o | wbm_sel_i[k*4 +: 4];
        wbs_cti_o = wbs_cti_o | wbm_cti_i[k*3 +: 3];
        wbs_bte_o = wbs_bte_o | wbm_bte_i[k*2 +: 2];
      end
    end
    wbs_cyc_o = bus_active & g_cyc;
    wbs_stb_o = bus_active & g_stb;
    wbs_we_o  = bus_active & g_we;
  end

  for (genvar gi = 0; gi < nm; gi++) begin : g_resp
    assign wbm_ack_o[gi] = grant_q[gi] & fwd & wbs_ack_i;
    assign wbm_err_o[gi] = grant_q[gi] & ((fwd & wbs_err_i) | expire);
    assign wbm_rty_o[gi] = grant_q[gi] & fwd & wbs_rty_i;
  end

  assign wbm_dat_o = wbs_dat_i;
  assign grant_o   = grant_q;

endmodule
